// File: rtl/eim_pkg.sv
// -----------------------------------------------------------------------------
// eim_pkg
// Shared definitions for the EIM multiplexed DA bus sequencer.
//   state_t        : sequencer state encoding (also exported as a debug output)
//   TIMEOUT_RDATA  : read data returned to the EIM master when the fabric times
//                    out. Wide enough for BUS_WIDTH up to 32; users slice the
//                    low 2*BUS_WIDTH bits.
// -----------------------------------------------------------------------------
package eim_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    REQ   = 3'd3,
    RD_LO = 3'd4,
    RD_HI = 3'd5
  } state_t;

  localparam logic [63:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/eim_da_ctrl.sv
// -----------------------------------------------------------------------------
// eim_da_ctrl
// Transaction sequencer for the multiplexed EIM DA pad buffer. Decodes i.MX EIM
// synchronous multiplexed cycles (address beat, then two data beats, low half
// first), turns them into one 32-bit request for the register fabric and
// stretches the EIM cycle with WAIT while the fabric is busy.
//
// Optional feature (macro EIM_DA_CTRL_TIMEOUT_EN): a REQ-state watchdog that
// abandons the fabric request after TIMEOUT_CYCLES, pulses err_timeout and
// returns all-ones read data. Without the macro REQ waits indefinitely.
//
// Ports
//   sys_clk, sys_rst          : clock, synchronous active-high reset
//   eim_bclk_rise             : one-cycle strobe per BCLK rising edge
//   eim_cs_n/lba_n/wr_n       : synchronized EIM controls
//   eim_wait_n                : 0 stalls the EIM master
//   phy_ro / phy_di / phy_t   : pad receiver, pad drive data, pad tristate
//   sys_addr/wr/rd/wdata      : fabric request (levels, held until sys_ack)
//   sys_rdata, sys_ack        : fabric completion
//   err_timeout               : one-cycle pulse on fabric timeout
//   state_dbg                 : current sequencer state
//
// Fabric handshake: sys_wr/sys_rd rise together with sys_addr/sys_wdata being
// stable and stay high until the first cycle sys_ack=1 is sampled; they drop on
// the following clock. sys_rdata is captured only on that ack cycle. sys_ack is
// ignored outside REQ.
// -----------------------------------------------------------------------------
module eim_da_ctrl
  import eim_pkg::*;
#(
  parameter int BUS_WIDTH      = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   eim_bclk_rise,
  input  logic                   eim_cs_n,
  input  logic                   eim_lba_n,
  input  logic                   eim_wr_n,
  output logic                   eim_wait_n,
  input  logic [BUS_WIDTH-1:0]   phy_ro,
  output logic [BUS_WIDTH-1:0]   phy_di,
  output logic                   phy_t,
  output logic [ADDR_WIDTH-1:0]  sys_addr,
  output logic                   sys_wr,
  output logic                   sys_rd,
  output logic [2*BUS_WIDTH-1:0] sys_wdata,
  input  logic [2*BUS_WIDTH-1:0] sys_rdata,
  input  logic                   sys_ack,
  output logic                   err_timeout,
  output state_t                 state_dbg
);

  localparam int DW = 2 * BUS_WIDTH;

  state_t                state_q, state_d;
  logic                  dir_q, dir_d;      // 1 = write
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DW-1:0]         wdata_d;
  logic                  err_d;
  logic                  req_d;
  logic                  timeout_hit;

`ifdef EIM_DA_CTRL_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] to_cnt_q;

  // Counts cycles already spent in REQ; zero on the first REQ cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state_q != REQ) to_cnt_q <= '0;
    else                           to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == REQ) && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rdata_d = rdata_q;
    addr_d  = sys_addr;
    wdata_d = sys_wdata;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (eim_bclk_rise && !eim_cs_n && !eim_lba_n) begin
        addr_d  = phy_ro[ADDR_WIDTH-1:0];
        dir_d   = ~eim_wr_n;
        state_d = eim_wr_n ? REQ : WR_LO;
      end
      WR_LO: if (eim_bclk_rise) begin
        if (eim_cs_n) state_d = IDLE;
        else begin
          wdata_d[BUS_WIDTH-1:0] = phy_ro;
          state_d = WR_HI;
        end
      end
      WR_HI: if (eim_bclk_rise) begin
        if (eim_cs_n) state_d = IDLE;
        else begin
          wdata_d[DW-1:BUS_WIDTH] = phy_ro;
          state_d = REQ;
        end
      end
      REQ: begin
        // sys_ack takes priority over a coincident timeout.
        if (sys_ack) begin
          if (dir_q) state_d = IDLE;
          else begin
            rdata_d = sys_rdata;
            state_d = eim_cs_n ? IDLE : RD_LO;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
          if (dir_q) state_d = IDLE;
          else begin
            rdata_d = TIMEOUT_RDATA[DW-1:0];
            state_d = eim_cs_n ? IDLE : RD_LO;
          end
        end
      end
      RD_LO: if (eim_bclk_rise) state_d = eim_cs_n ? IDLE : RD_HI;
      RD_HI: if (eim_bclk_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered copies of values derived from the next state, so
  // they line up exactly with the state register.
  assign req_d = (state_d == REQ);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      rdata_q     <= '0;
      sys_addr    <= '0;
      sys_wdata   <= '0;
      sys_wr      <= 1'b0;
      sys_rd      <= 1'b0;
      eim_wait_n  <= 1'b1;
      phy_t       <= 1'b1;
      phy_di      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      rdata_q     <= rdata_d;
      sys_addr    <= addr_d;
      sys_wdata   <= wdata_d;
      sys_wr      <= req_d && dir_d;
      sys_rd      <= req_d && !dir_d;
      eim_wait_n  <= !req_d;
      phy_t       <= !(state_d == RD_LO || state_d == RD_HI);
      phy_di      <= (state_d == RD_LO) ? rdata_d[BUS_WIDTH-1:0] :
                     (state_d == RD_HI) ? rdata_d[DW-1:BUS_WIDTH] : '0;
      err_timeout <= err_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_eim_da_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eim_da_ctrl
// Directed bench for eim_da_ctrl. An EIM master driver issues beats, a fabric
// model answers requests after a programmable delay, and a monitor turns DUT
// activity into events checked against an expected-event queue.
// Build with +define+EIM_DA_CTRL_TIMEOUT_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_eim_da_ctrl;
  import eim_pkg::*;

  localparam int BW = 16;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int EW = 52;

  localparam logic [3:0] K_WR   = 4'd1;
  localparam logic [3:0] K_RD   = 4'd2;
  localparam logic [3:0] K_BOTH = 4'd3;
  localparam logic [3:0] K_WAIT = 4'd4;
  localparam logic [3:0] K_DRV  = 4'd5;
  localparam logic [3:0] K_TO   = 4'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 clk = ~clk;

  logic          eim_bclk_rise = 1'b0;
  logic          eim_cs_n = 1'b1;
  logic          eim_lba_n = 1'b1;
  logic          eim_wr_n = 1'b1;
  logic          eim_wait_n;
  logic [BW-1:0] phy_ro = '0;
  logic [BW-1:0] phy_di;
  logic          phy_t;
  logic [AW-1:0] sys_addr;
  logic          sys_wr;
  logic          sys_rd;
  logic [DW-1:0] sys_wdata;
  logic [DW-1:0] sys_rdata = '0;
  logic          sys_ack = 1'b0;
  logic          err_timeout;
  state_t        state_dbg;

  eim_da_ctrl #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .eim_bclk_rise(eim_bclk_rise),
    .eim_cs_n(eim_cs_n), .eim_lba_n(eim_lba_n), .eim_wr_n(eim_wr_n),
    .eim_wait_n(eim_wait_n), .phy_ro(phy_ro), .phy_di(phy_di), .phy_t(phy_t),
    .sys_addr(sys_addr), .sys_wr(sys_wr), .sys_rd(sys_rd), .sys_wdata(sys_wdata),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .err_timeout(err_timeout),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] ev(input logic [3:0] k, input logic [15:0] a,
                                       input logic [31:0] d);
    return {k, a, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic observe(input string name, input logic [EW-1:0] got);
    logic [EW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got event %h want none", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got event %h want %h", name, got, e);
      end
    end
  endtask

  // ---------------- monitor ----------------
  int   wait_cnt = 0;
  int   t_low_cnt = 0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (sys_rst) begin
      wait_cnt = 0;
      prev_req = 1'b0;
    end else begin
      if ((sys_wr || sys_rd) && !prev_req)
        observe("req", ev((sys_wr && sys_rd) ? K_BOTH : (sys_wr ? K_WR : K_RD),
                          sys_addr, sys_wr ? sys_wdata : 32'h0));
      prev_req = sys_wr || sys_rd;
      if (!eim_wait_n) wait_cnt++;
      else if (wait_cnt > 0) begin
        observe("wait_len", ev(K_WAIT, 16'h0, 32'(wait_cnt)));
        wait_cnt = 0;
      end
      if (err_timeout) observe("timeout", ev(K_TO, 16'h0, 32'h0));
      if (!phy_t) t_low_cnt++;
      if (eim_bclk_rise && !phy_t) observe("drive", ev(K_DRV, 16'h0, {16'h0, phy_di}));
    end
  end

  // ---------------- fabric model ----------------
  int            fab_delay = 1;   // ack on this request cycle; 0 = never
  logic [DW-1:0] fab_rdata = '0;
  int            fab_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    if (sys_wr || sys_rd) begin
      fab_cnt++;
      sys_ack = (fab_delay != 0) && (fab_cnt == fab_delay);
    end else begin
      fab_cnt = 0;
      sys_ack = 1'b0;
    end
    sys_rdata = sys_ack ? fab_rdata : 32'h5A5A_5A5A;
  end

  // ---------------- EIM master driver ----------------
  task automatic beat(input logic cs_n, input logic lba_n, input logic wr_n,
                      input logic [15:0] d);
    eim_cs_n = cs_n; eim_lba_n = lba_n; eim_wr_n = wr_n; phy_ro = d;
    eim_bclk_rise = 1'b1;
    @(posedge clk); #1;
    eim_bclk_rise = 1'b0; eim_lba_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!eim_wait_n && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!eim_wait_n) begin
      total++; bad++;
      $display("FAIL %s: wait_n still low after %0d cycles, want 1", name, n);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi,
                          input int delay, input logic data_lba_n);
    fab_delay = delay;
    exp_q.push_back(ev(K_WR, a, {hi, lo}));
    exp_q.push_back(ev(K_WAIT, 16'h0, 32'(delay)));
    beat(1'b0, 1'b0, 1'b0, a);
    beat(1'b0, data_lba_n, 1'b0, lo);
    beat(1'b0, data_lba_n, 1'b0, hi);
    wait_ready("write_wait");
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] rdata, input int delay,
                         input int wait_len, input logic to, input logic [31:0] drv);
    fab_delay = delay;
    fab_rdata = rdata;
    exp_q.push_back(ev(K_RD, a, 32'h0));
    exp_q.push_back(ev(K_WAIT, 16'h0, 32'(wait_len)));
    if (to) exp_q.push_back(ev(K_TO, 16'h0, 32'h0));
    exp_q.push_back(ev(K_DRV, 16'h0, {16'h0, drv[15:0]}));
    exp_q.push_back(ev(K_DRV, 16'h0, {16'h0, drv[31:16]}));
    beat(1'b0, 1'b0, 1'b1, a);
    wait_ready("read_wait");
    beat(1'b0, 1'b1, 1'b1, 16'h0);
    beat(1'b0, 1'b1, 1'b1, 16'h0);
    chk("read_release_phy_t", 32'(phy_t), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sys_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait_n", 32'(eim_wait_n), 32'd1);
    chk("rst_phy_t", 32'(phy_t), 32'd1);
    chk("rst_phy_di", 32'(phy_di), 32'd0);
    chk("rst_sys_wr", 32'(sys_wr), 32'd0);
    chk("rst_sys_rd", 32'(sys_rd), 32'd0);
    chk("rst_sys_addr", 32'(sys_addr), 32'd0);
    chk("rst_sys_wdata", sys_wdata, 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    sys_rst = 1'b0;
    @(posedge clk); #1;

    // basic write; the pads must never be driven
    t_low_cnt = 0;
    do_write(16'h0123, 16'hBEEF, 16'hDEAD, 3, 1'b1);
    chk("write_phy_t_low_cycles", 32'(t_low_cnt), 32'd0);
    eim_cs_n = 1'b1;
    @(posedge clk); #1;

    // basic read
    do_read(16'h0040, 32'hCAFE_F00D, 2, 2, 1'b0, 32'hCAFE_F00D);
    eim_cs_n = 1'b1;
    @(posedge clk); #1;

    // write aborted by cs_n after the first data beat
    beat(1'b0, 1'b0, 1'b0, 16'h0200);
    beat(1'b0, 1'b1, 1'b0, 16'h1111);
    beat(1'b1, 1'b1, 1'b0, 16'h2222);
    chk("abort_state", 32'(state_dbg), 32'(IDLE));
    chk("abort_sys_wr", 32'(sys_wr), 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // back-to-back read then write, lba_n low on write data beats is ignored
    do_read(16'h0055, 32'h1234_5678, 1, 1, 1'b0, 32'h1234_5678);
    do_write(16'h0066, 16'hAAAA, 16'h5555, 1, 1'b0);
    chk("b2b_addr", 32'(sys_addr), 32'h0066);
    eim_cs_n = 1'b1;
    @(posedge clk); #1;

    // reset while in RD_HI
    fab_delay = 1;
    fab_rdata = 32'h0BAD_F00D;
    exp_q.push_back(ev(K_RD, 16'h0077, 32'h0));
    exp_q.push_back(ev(K_WAIT, 16'h0, 32'd1));
    exp_q.push_back(ev(K_DRV, 16'h0, 32'h0000_F00D));
    beat(1'b0, 1'b0, 1'b1, 16'h0077);
    wait_ready("rst_read_wait");
    beat(1'b0, 1'b1, 1'b1, 16'h0);
    chk("pre_rst_state", 32'(state_dbg), 32'(RD_HI));
    sys_rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_phy_t", 32'(phy_t), 32'd1);
    chk("mid_rst_wait_n", 32'(eim_wait_n), 32'd1);
    chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    chk("mid_rst_phy_di", 32'(phy_di), 32'd0);
    sys_rst = 1'b0;
    eim_cs_n = 1'b1;
    @(posedge clk); #1;

    // cs_n deasserted while the read request is pending: complete, no drive
    fab_delay = 4;
    fab_rdata = 32'h1111_2222;
    exp_q.push_back(ev(K_RD, 16'h0088, 32'h0));
    exp_q.push_back(ev(K_WAIT, 16'h0, 32'd4));
    beat(1'b0, 1'b0, 1'b1, 16'h0088);
    eim_cs_n = 1'b1;
    wait_ready("cs_read_wait");
    beat(1'b1, 1'b1, 1'b1, 16'h0);
    beat(1'b1, 1'b1, 1'b1, 16'h0);
    chk("cs_read_phy_t", 32'(phy_t), 32'd1);
    chk("cs_read_state", 32'(state_dbg), 32'(IDLE));

`ifdef EIM_DA_CTRL_TIMEOUT_EN
    // no ack: watchdog fires, all-ones data is driven
    do_read(16'h0099, 32'h0, 0, 4, 1'b1, 32'hFFFF_FFFF);
    eim_cs_n = 1'b1;
    @(posedge clk); #1;
    // ack on the last allowed cycle wins over the timeout
    do_read(16'h009A, 32'h8765_4321, 4, 4, 1'b0, 32'h8765_4321);
    eim_cs_n = 1'b1;
    @(posedge clk); #1;
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eim_da_ctrl.md
Name: eim_da_ctrl

Overview:
- Transaction sequencer for the multiplexed EIM DA bus pad buffer.
- Decodes i.MX EIM synchronous multiplexed cycles: one address beat, then two 16-bit data beats, low half first.
- Drives the pad buffer's drive-data and tristate controls, and samples its receiver output.
- Presents a single 32-bit read/write request with a req/ack handshake to the system-side register fabric.
- Stretches the EIM cycle with WAIT while the fabric is busy.

Parameters:
- BUS_WIDTH, 16: DA pad width; one data beat.
- ADDR_WIDTH, 16: captured address width; must be <= BUS_WIDTH.
- TIMEOUT_CYCLES, 255: sys_clk cycles allowed for sys_ack. Used only with the optional feature.

Ports:
- sys_clk  in  1  single clock for all logic.
- sys_rst  in  1  reset, synchronous, active-high.
- eim_bclk_rise  in  1  one-cycle strobe per EIM BCLK rising edge; already synchronized to sys_clk.
- eim_cs_n  in  1  chip select, active low, synchronized.
- eim_lba_n  in  1  address-valid strobe, active low, synchronized.
- eim_wr_n  in  1  0 = write, 1 = read, synchronized.
- eim_wait_n  out  1  0 stalls the EIM master.
- phy_ro  in  BUS_WIDTH  value sampled from pins (pad buffer receiver output).
- phy_di  out  BUS_WIDTH  value to drive onto pins.
- phy_t  out  1  1 = pads tristated.
- sys_addr  out  ADDR_WIDTH  request address.
- sys_wr  out  1  write request, level.
- sys_rd  out  1  read request, level.
- sys_wdata  out  2*BUS_WIDTH  write data.
- sys_rdata  in  2*BUS_WIDTH  read data; valid when sys_ack=1.
- sys_ack  in  1  request completion.
- err_timeout  out  1  one-cycle pulse on a fabric timeout.

Behaviour:
- Reset values: eim_wait_n=1, phy_t=1, phy_di=0, sys_wr=0, sys_rd=0, sys_addr=0, sys_wdata=0, err_timeout=0, state=IDLE.
- Reset mid-transaction aborts immediately and never issues a request.
- All outputs are registered.
- Every state except REQ advances only on cycles where eim_bclk_rise=1. REQ advances on sys_ack.
- IDLE: on strobe with cs_n=0 and lba_n=0:
  - sys_addr <= phy_ro[ADDR_WIDTH-1:0];
  - latch dir = ~wr_n;
  - go to WR_LO for a write, REQ for a read.
- WR_LO: on strobe, sys_wdata[BUS_WIDTH-1:0] <= phy_ro; go to WR_HI.
- WR_HI: on strobe, sys_wdata upper half <= phy_ro; go to REQ.
- REQ:
  - sys_wr or sys_rd = 1 (per dir) and eim_wait_n = 0, held until sys_ack.
  - On the sys_ack cycle the request drops on the next clock and eim_wait_n returns to 1.
  - Read: latch sys_rdata and go to RD_LO. Write: go to IDLE.
  - sys_ack is ignored in every state other than REQ.
- RD_LO: phy_t=0, phy_di = rdata low half. On strobe go to RD_HI.
- RD_HI: phy_di = rdata high half. On strobe go to IDLE with phy_t=1.
- Turnaround: phy_t=0 only in RD_LO and RD_HI. The write path never drives the pads.
- cs_n=1 seen on a strobe in WR_LO, WR_HI, RD_LO or RD_HI: abort to IDLE and set phy_t=1 the next cycle. No request is issued for an aborted write.
- cs_n is ignored in REQ; the request always completes. If cs_n=1 when sys_ack arrives on a read, go to IDLE without driving.
- lba_n=0 outside IDLE is ignored.
- A new address beat is accepted on the first strobe in IDLE, so back-to-back transactions are allowed.
- err_timeout stays 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: EIM_DA_CTRL_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on REQ entry and increments each cycle in REQ.
  - On reaching TIMEOUT_CYCLES without sys_ack: drop sys_wr/sys_rd and pulse err_timeout for one cycle.
  - A read then returns all-ones data through RD_LO/RD_HI; a write returns to IDLE.
  - A sys_ack arriving on the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter; REQ waits indefinitely; err_timeout tied to 0.

Decomposition:
- Shared package eim_pkg:
  - state encoding enum: IDLE, WR_LO, WR_HI, REQ, RD_LO, RD_HI;
  - TIMEOUT_RDATA = all-ones constant.
- No sub-module; the optional timeout counter stays inline.

Test Plan:
- Write: address beat 0x0123, data beats 0xBEEF then 0xDEAD, sys_ack after 3 cycles -> sys_wr=1 with sys_addr=0x0123, sys_wdata=0xDEADBEEF; eim_wait_n=0 for 3 cycles; phy_t stays 1.
- Read: address 0x0040, sys_rdata=0xCAFEF00D on ack -> phy_t=0, phy_di=0xF00D, then 0xCAFE on the next strobe; phy_t=1 after the second strobe.
- cs_n raised after WR_LO -> return to IDLE; sys_wr never asserts.
- Back-to-back read then write with no idle strobe -> both complete; sys_addr updates per transaction.
- sys_rst asserted during RD_HI -> next cycle phy_t=1, eim_wait_n=1, state IDLE.
- EIM_DA_CTRL_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack on a read -> err_timeout pulses; phy_di drives 0xFFFF twice. Ack on the 4th cycle -> normal completion, no pulse.
